// File: rtl/reg_wb_sched.sv
// reg_wb_sched: register-file writeback scheduler.
// Two writeback sources (auto-increment/SP update and ALU result) share one
// register-file write port through a small in-order FIFO. Requests are
// accepted one per cycle with inc taking priority. Writes to R3 (the constant
// generator) are acknowledged and dropped. A read-hazard check raises stall
// while a decoder read address matches any write that has not yet landed.
module reg_wb_sched #(
    parameter int QDEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_req,
    input  logic [3:0]  inc_da,
    input  logic [15:0] inc_data,
    output logic        inc_ack,
    input  logic        alu_req,
    input  logic [3:0]  alu_da,
    input  logic [15:0] alu_data,
    output logic        alu_ack,
    input  logic        rd_chk,
    input  logic [3:0]  rd_sa,
    input  logic [3:0]  rd_da,
    output logic        stall,
    input  logic        flush,
    output logic        rf_rw,
    output logic [3:0]  rf_da,
    output logic [15:0] rf_din,
    output logic [4:0]  q_count,
    output logic [15:0] wr_count
);

    localparam int          PW      = $clog2(QDEPTH);
    localparam logic [4:0]  DEPTH_C = 5'(QDEPTH);
    localparam logic [3:0]  CG_REG  = 4'd3;

    logic [3:0]    q_da   [QDEPTH];
    logic [15:0]   q_data [QDEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [4:0]    count;

    logic          can_accept;
    logic          acked;
    logic [3:0]    push_da;
    logic [15:0]   push_data;
    logic          push;
    logic          pop;
    logic [QDEPTH-1:0] valid;
    logic          sa_hit;
    logic          da_hit;

    assign q_count = count;

    // Acceptance: one request per cycle, inc has priority, nothing while full,
    // flushing or in reset (a pop in the same cycle does not free a slot).
    always_comb begin
        can_accept = !rst && !flush && (count < DEPTH_C);
        inc_ack    = inc_req && can_accept;
        alu_ack    = alu_req && !inc_req && can_accept;
        acked      = inc_ack || alu_ack;
        push_da    = inc_ack ? inc_da   : alu_da;
        push_data  = inc_ack ? inc_data : alu_data;
        push       = acked && (push_da != CG_REG);
        pop        = (count != 5'd0) && !flush;
    end

    // Hazard detection against queued entries, the write on the port and the
    // request being accepted right now.
    always_comb begin
        // NOTE: every signal assigned in an always_comb gets a default first so
        // no path leaves it unassigned, which would otherwise infer a latch.
        valid  = '0;
        sa_hit = 1'b0;
        da_hit = 1'b0;
        for (int i = 0; i < QDEPTH; i++) begin
            valid[i] = (5'(PW'(i) - rd_ptr) < count);
            if (valid[i] && q_da[i] == rd_sa) sa_hit = 1'b1;
            if (valid[i] && q_da[i] == rd_da) da_hit = 1'b1;
        end
        if (rf_rw && rf_da == rd_sa)  sa_hit = 1'b1;
        if (rf_rw && rf_da == rd_da)  da_hit = 1'b1;
        if (acked && push_da == rd_sa) sa_hit = 1'b1;
        if (acked && push_da == rd_da) da_hit = 1'b1;
        stall = rd_chk && (((rd_sa != CG_REG) && sa_hit) ||
                           ((rd_da != CG_REG) && da_hit));
    end

    // FIFO pointers and occupancy; flush and reset both empty the queue.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 5'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + {4'b0, push} - {4'b0, pop};
        end
    end

    // FIFO storage; contents are qualified by count so they need no reset.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; occupancy alone
        // decides which entries are meaningful, so the RAM stays reset-free.
        if (push) begin
            q_da[wr_ptr]   <= push_da;
            q_data[wr_ptr] <= push_data;
        end
    end

    // Registered register-file write port and issued-write counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_rw    <= 1'b0;
            rf_da    <= 4'd0;
            rf_din   <= 16'd0;
            wr_count <= 16'd0;
        end else if (pop) begin
            rf_rw    <= 1'b1;
            rf_da    <= q_da[rd_ptr];
            rf_din   <= q_data[rd_ptr];
            wr_count <= wr_count + 16'd1;
        end else begin
            rf_rw    <= 1'b0;
        end
    end

endmodule
